mult_pipe_ctrl: RTL and testbench

//   Sequences the 2-stage pipelined unsigned WIDTHxWIDTH multiplier of the calculator datapath.
//   - Stage 1 forms the lower-half partial-product sum (PP0plus1) and the upper-half sum (PP2plus3).
//   - Stage 2 feeds both sums to the CLA-based final adder, mult_final_add, which produces P.
//   - Owns the valid/ready handshakes, the stage registers and backpressure/flush; sits between

---
 rtl/mult_pkg.sv | 29 ++
 rtl/mult_final_add.sv | 48 ++++
 rtl/mult_pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_mult_pipe_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined unsigned multiplier.
package mult_pkg;

    localparam int MULT_W = 4;
    localparam int PROD_W = 2 * MULT_W;

    typedef logic [PROD_W-1:0] prod_t;

    // Pipeline occupancy, encoded as {s2_vld, s1_vld}.
    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'b00,
        PIPE_S1    = 2'b01,
        PIPE_FLOW  = 2'b10,
        PIPE_FULL  = 2'b11
    } pipe_state_t;

    // Partial product row i: (a << i) when b[i] is set, zero-extended to PROD_W.
    function automatic prod_t pp_row(input logic [MULT_W-1:0] a,
                                     input logic [MULT_W-1:0] b,
                                     input int i);
        prod_t row;
        row = '0;
        if (b[i]) begin
            row = prod_t'(a) << i;
        end
        return row;
    endfunction

endpackage

// File: rtl/mult_final_add.sv
// Final product adder: 4-bit carry-lookahead slices chained by ripple carry.
// W must be a multiple of 4. The carry out of the top slice is not formed,
// since the product of two valid operands never overflows.
module mult_final_add
    import mult_pkg::*;
#(
    parameter int W = PROD_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum
);
    localparam int NS = W / 4;

    logic [NS-1:0] c;

    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < NS; gi++) begin : g_slice
            logic [3:0] g;
            logic [3:0] pr;
            logic [3:0] cc;

            assign g  = x[gi*4 +: 4] & y[gi*4 +: 4];
            assign pr = x[gi*4 +: 4] ^ y[gi*4 +: 4];

            // Lookahead carries inside the slice.
            assign cc[0] = c[gi];
            assign cc[1] = g[0] | (pr[0] & cc[0]);
            assign cc[2] = g[1] | (pr[1] & g[0]) | (pr[1] & pr[0] & cc[0]);
            assign cc[3] = g[2] | (pr[2] & g[1]) | (pr[2] & pr[1] & g[0])
                         | (pr[2] & pr[1] & pr[0] & cc[0]);

            assign sum[gi*4 +: 4] = pr ^ cc;

            // Group carry ripples into the next slice.
            if (gi < NS - 1) begin : g_carry
                assign c[gi+1] = g[3] | (pr[3] & g[2]) | (pr[3] & pr[2] & g[1])
                               | (pr[3] & pr[2] & pr[1] & g[0])
                               | (pr[3] & pr[2] & pr[1] & pr[0] & cc[0]);
            end
        end
    endgenerate

endmodule

// File: rtl/mult_pipe_ctrl.sv
// Two-stage pipelined unsigned multiplier controller.
// Stage 1 registers the lower/upper partial-product sums, stage 2 registers
// the final sum. Optional performance counters are enabled by defining
// MULT_PERF_CNT_EN.
module mult_pipe_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
`ifdef MULT_PERF_CNT_EN
    ,
    output logic [15:0]        perf_ops,
    output logic [15:0]        perf_stall
`endif
);
    localparam int HALF = WIDTH / 2;

    pipe_state_t state_reg, state_next;
    logic        s1_vld, s2_vld;
    logic        s1_adv, s2_adv, accept, s2_load;
    prod_t       pp [WIDTH];
    prod_t       lo_sum, hi_sum, final_sum;
    prod_t       pp_lo_reg, pp_hi_reg, p_reg;

    assign s1_vld    = state_reg[0];
    assign s2_vld    = state_reg[1];
    assign out_valid = s2_vld;
    assign busy      = s1_vld | s2_vld;
    assign p         = p_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pp
            assign pp[gi] = pp_row(a, b, gi);
        end
    endgenerate

    // Split the partial-product rows into lower-half and upper-half sums.
    always_comb begin
        lo_sum = '0;
        hi_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < HALF) begin
                lo_sum = lo_sum + pp[i];
            end else begin
                hi_sum = hi_sum + pp[i];
            end
        end
    end

    mult_final_add #(.W(PROD_W)) u_final_add (
        .x   (pp_lo_reg),
        .y   (pp_hi_reg),
        .cin (1'b0),
        .sum (final_sum)
    );

    // Advance terms, handshake and next occupancy state.
    always_comb begin
        s2_adv     = !s2_vld || out_ready;
        s1_adv     = !s1_vld || s2_adv;
        in_ready   = s1_adv && !flush && !rst;
        accept     = in_valid && in_ready;
        s2_load    = s2_adv && s1_vld && !flush;
        state_next = state_reg;
        if (flush) begin
            state_next = PIPE_EMPTY;
        end else begin
            state_next = pipe_state_t'({(s2_adv ? s1_vld : s2_vld),
                                        (s1_adv ? accept : s1_vld)});
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= PIPE_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Stage data registers; p holds while stage 2 is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pp_lo_reg <= '0;
            pp_hi_reg <= '0;
            p_reg     <= '0;
        end else begin
            if (accept) begin
                pp_lo_reg <= lo_sum;
                pp_hi_reg <= hi_sum;
            end
            if (s2_load) begin
                p_reg <= final_sum;
            end
        end
    end

`ifdef MULT_PERF_CNT_EN
    logic [15:0] perf_ops_reg, perf_stall_reg;

    assign perf_ops   = perf_ops_reg;
    assign perf_stall = perf_stall_reg;

    // Delivered-product and stalled-cycle counters; flush leaves them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_reg   <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (s2_vld && out_ready) begin
                perf_ops_reg <= perf_ops_reg + 16'd1;
            end
            if (s2_vld && !out_ready) begin
                perf_stall_reg <= perf_stall_reg + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_pipe_ctrl.sv
// Self-checking bench for mult_pipe_ctrl: vector table plus hand-written
// stall/flush/reset sequences, with a scoreboard on delivered products.
module tb_mult_pipe_ctrl;
    import mult_pkg::*;

    localparam int W = MULT_W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           in_ready, out_valid, busy;
    logic [2*W-1:0] p;
`ifdef MULT_PERF_CNT_EN
    logic [15:0]    perf_ops, perf_stall;
`endif

    int total = 0;
    int bad = 0;
    bit quiet = 1'b0;
    logic [2*W-1:0] sb [$];

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;
    vec_t tbl [8];

    mult_pipe_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
`ifdef MULT_PERF_CNT_EN
        ,
        .perf_ops  (perf_ops),
        .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one operand pair for one cycle; it must be accepted.
    task automatic offer(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] e);
        a = x;
        b = y;
        in_valid = 1'b1;
        #1;
        chk("offer_in_ready", in_ready, 1);
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    // Scoreboard: compare every delivered product in order; rst/flush drop in-flight entries.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            chk("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                logic [2*W-1:0] e;
                e = sb.pop_front();
                if (!quiet) $display("xfer p=0x%02h expected=0x%02h", p, e);
                chk("sb_p", p, e);
            end
        end
    end

    initial begin
        tbl[0] = '{4'd3,  4'd5,  8'h0F};
        tbl[1] = '{4'd0,  4'd9,  8'h00};
        tbl[2] = '{4'd15, 4'd1,  8'h0F};
        tbl[3] = '{4'd8,  4'd8,  8'h40};
        tbl[4] = '{4'd15, 4'd15, 8'hE1};
        tbl[5] = '{4'd1,  4'd1,  8'h01};
        tbl[6] = '{4'd10, 4'd12, 8'h78};
        tbl[7] = '{4'd7,  4'd9,  8'h3F};

        // Reset state
        tick(2);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_p", p, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);

        // Single op 15*15 with exact latency
        a = 4'd15; b = 4'd15; in_valid = 1'b1;
        #1;
        chk("t1_in_ready", in_ready, 1);
        sb.push_back(8'hE1);
        tick();
        in_valid = 1'b0;
        chk("t1_ovalid_e1", out_valid, 0);
        chk("t1_busy_e1", busy, 1);
        tick();
        chk("t1_ovalid_e2", out_valid, 1);
        chk("t1_p", p, 8'hE1);
        tick();
        chk("t1_ovalid_e3", out_valid, 0);
        chk("t1_busy_e3", busy, 0);

        // Back-to-back stream from the vector table
        for (int i = 0; i < 8; i++) begin
            a = tbl[i].a; b = tbl[i].b; in_valid = 1'b1;
            #1;
            chk("t2_in_ready", in_ready, 1);
            sb.push_back(tbl[i].exp);
            tick();
            if (i >= 1) begin
                chk("t2_ovalid", out_valid, 1);
                chk("t2_p", p, tbl[i-1].exp);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("t2_ovalid_last", out_valid, 1);
        chk("t2_p_last", p, tbl[7].exp);
        tick();
        chk("t2_busy_end", busy, 0);

        // Backpressure: two ops held, third refused
        out_ready = 1'b0;
        offer(4'd6, 4'd7, 8'h2A);
        offer(4'd9, 4'd9, 8'h51);
        a = 4'd1; b = 4'd1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_in_ready", in_ready, 0);
            chk("t3_ovalid", out_valid, 1);
            chk("t3_p_hold", p, 8'h2A);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("t3_ovalid_rel", out_valid, 1);
        chk("t3_p_second", p, 8'h51);
        tick();
        chk("t3_ovalid_end", out_valid, 0);

        // Flush discards (2,3) and refuses the flush-cycle input
        offer(4'd2, 4'd3, 8'h06);
        flush = 1'b1;
        a = 4'd5; b = 4'd5; in_valid = 1'b1;
        #1;
        chk("t4_in_ready_flush", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t4_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            chk("t4_ovalid", out_valid, 0);
            tick();
        end

        // Reset with both stages full and stalled
        out_ready = 1'b0;
        offer(4'd3, 4'd3, 8'h09);
        offer(4'd2, 4'd2, 8'h04);
        chk("t5_busy_full", busy, 1);
        chk("t5_ovalid_full", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_in_ready_rst", in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("t5_ovalid", out_valid, 0);
        chk("t5_p", p, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_busy", busy, 0);

`ifdef MULT_PERF_CNT_EN
        // Performance counters: 3 ops, 5 stalls, then wrap
        chk("t6_ops_init", perf_ops, 0);
        chk("t6_stall_init", perf_stall, 0);
        offer(4'd1, 4'd2, 8'h02);
        offer(4'd2, 4'd2, 8'h04);
        tick(5);
        chk("t6_stall_5", perf_stall, 5);
        chk("t6_ops_0", perf_ops, 0);
        out_ready = 1'b1;
        offer(4'd3, 4'd2, 8'h06);
        tick(2);
        chk("t6_ops_3", perf_ops, 3);
        chk("t6_stall_keep", perf_stall, 5);
        chk("t6_busy", busy, 0);
        quiet = 1'b1;
        a = 4'd1; b = 4'd1; in_valid = 1'b1;
        for (int i = 0; i < 65532; i++) begin
            sb.push_back(8'h01);
            tick();
        end
        in_valid = 1'b0;
        tick(2);
        chk("t6_ops_ffff", perf_ops, 16'hFFFF);
        quiet = 1'b0;
        offer(4'd1, 4'd1, 8'h01);
        tick(2);
        chk("t6_ops_wrap", perf_ops, 16'h0000);
        chk("t6_stall_final", perf_stall, 5);
`endif

        tick(2);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
